param_updn_counter: RTL and testbench
=====================================

PARAM_UPDN_COUNTER -- requirements
Module: param_updn_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 3, counter width in bits (legal 2..32).
REQ-002 The block SHALL have parameter SAT_MODE, default 0: 0 = wrap at the range ends, 1 = saturate at the range ends.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset that is asynchronous and active-high.
REQ-005 The block SHALL have port en, input, 1, count enable.
REQ-006 The block SHALL have port up, input, 1: 1 = count up, 0 = count down.
REQ-007 The block SHALL have port step, input, WIDTH, increment or decrement magnitude.
REQ-008 The block SHALL have port limit, input, WIDTH, upper bound of the count range 0..limit.
REQ-009 The block SHALL have port load, input, 1, synchronous load strobe.
REQ-010 The block SHALL have port load_val, input, WIDTH, value to load.
REQ-011 The block SHALL have port clr_err, input, 1, clears err.
REQ-012 The block SHALL have port count, output, WIDTH, registered count.
REQ-013 The block SHALL have port wrap, output, 1, registered one-cycle pulse on any wrap or saturation event.
REQ-014 The block SHALL have port at_max, output, 1, combinational, asserted when count == limit.
REQ-015 The block SHALL have port at_min, output, 1, combinational, asserted when count == 0.
REQ-016 The block SHALL have port err, output, 1, sticky illegal-step flag.

Function
REQ-017 Per-cycle priority SHALL be: load, then en, then hold.
REQ-018 On load, count SHALL take min(load_val, limit) on the next edge; wrap SHALL be 0 that cycle.
REQ-019 With en=1 and step=0, count SHALL hold and wrap SHALL stay 0.
REQ-020 Next-value arithmetic SHALL use WIDTH+1 bits, so no intermediate overflow is possible.
REQ-021 Up, count+step <= limit: count SHALL become count+step.
REQ-022 Up, count+step > limit: count SHALL become count+step-(limit+1) in wrap mode, or limit in saturate mode; wrap SHALL pulse.
REQ-023 Down, count >= step: count SHALL become count-step.
REQ-024 Down, count < step: count SHALL become count+(limit+1)-step in wrap mode, or 0 in saturate mode; wrap SHALL pulse.
REQ-025 Saturate mode at limit counting up, or at 0 counting down, SHALL hold the value and pulse wrap every enabled cycle.
REQ-026 With en=1 and step > limit: count SHALL hold, err SHALL set, and wrap SHALL stay 0.
REQ-027 If count > limit (limit lowered at runtime) and en=1: count SHALL go to 0 in wrap mode or to limit in saturate mode, and wrap SHALL pulse.
REQ-028 err SHALL stay set until clr_err=1; if clr_err and a new error occur in the same cycle, err SHALL remain set.
REQ-029 wrap SHALL deassert on the cycle after its event unless a new event occurs.
REQ-030 With limit=0, count SHALL stay 0 and at_max and at_min SHALL both be asserted.

Reset
REQ-031 While rst=1, count SHALL be 0, wrap 0 and err 0, asynchronously.
REQ-032 Deasserting rst mid-operation SHALL resume counting from 0 on the first edge with en=1.
REQ-033 The outputs SHALL produce no spurious wrap pulse on reset release.

Structure
REQ-034 The shared package updn_pkg SHALL hold the MODE_WRAP/MODE_SAT constants and the WIDTH legality bounds.
REQ-035 The pure combinational next-value and event logic SHALL sit in one sub-module, updn_next_calc; the top holds the registers and flags.

Verification
REQ-036 The bench SHALL cover: WIDTH=3, wrap mode, limit=7, step=1, up for 9 cycles -> count 1..7,0,1; wrap pulses once at 7->0.
REQ-037 The bench SHALL cover: WIDTH=3, wrap mode, limit=5, step=2, down from 1 -> count 5, then 3; wrap pulses only on 1->5.
REQ-038 The bench SHALL cover: saturate mode, limit=6, step=3, up from 4 -> count 6 with wrap, then 6 with wrap again; at_max=1.
REQ-039 The bench SHALL cover: load=1, load_val=7, limit=4 -> count 4, wrap 0; load and en together -> load wins.
REQ-040 The bench SHALL cover: step=6, limit=5, en=1 -> count holds and err sets; clr_err -> err 0; limit lowered from 7 to 2 at count=6 -> count 0 (wrap mode) with wrap pulse.
REQ-041 The bench SHALL cover: rst asserted asynchronously between edges at count=5 -> count 0 immediately; release -> counting restarts from 0.

Source files
------------

// File: rtl/updn_pkg.sv
// Shared constants for the parameterised up/down counter: mode encodings
// and the legal range of the WIDTH parameter.
package updn_pkg;
  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;
  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;
endpackage

// File: rtl/updn_next_calc.sv
// Pure combinational next-count and wrap/saturate event logic for one
// enabled cycle. It uses WIDTH+1 bit arithmetic, so sums never overflow.
module updn_next_calc
  import updn_pkg::*;
#(
  parameter int WIDTH    = 3,
  parameter int SAT_MODE = MODE_WRAP
) (
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] limit,
  input  logic             up,
  output logic [WIDTH-1:0] nxt,
  output logic             evt,
  output logic             step_err
);
  localparam bit             SAT = (SAT_MODE == MODE_SAT);
  localparam logic [WIDTH:0] ONE = (WIDTH+1)'(1);

  logic [WIDTH:0] c_x, s_x, l_x, sum, wrap_up, wrap_dn;

  assign c_x     = {1'b0, count};
  assign s_x     = {1'b0, step};
  assign l_x     = {1'b0, limit};
  assign sum     = c_x + s_x;
  assign wrap_up = sum - l_x - ONE;
  assign wrap_dn = c_x + l_x + ONE - s_x;

  always_comb begin
    nxt      = count;
    evt      = 1'b0;
    step_err = 1'b0;
    if (step > limit) begin
      step_err = 1'b1;
    end else if (count > limit) begin
      // limit was lowered beneath the current count: snap back into range
      nxt = SAT ? limit : '0;
      evt = 1'b1;
    end else if (step != '0) begin
      if (up) begin
        if (sum <= l_x) begin
          nxt = sum[WIDTH-1:0];
        end else begin
          nxt = SAT ? limit : wrap_up[WIDTH-1:0];
          evt = 1'b1;
        end
      end else begin
        if (count >= step) begin
          nxt = count - step;
        end else begin
          nxt = SAT ? '0 : wrap_dn[WIDTH-1:0];
          evt = 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/param_updn_counter.sv
// Up/down counter over 0..limit with a programmable step, a load that takes
// priority over counting, a one-cycle wrap pulse and a sticky step error.
module param_updn_counter
  import updn_pkg::*;
#(
  parameter int WIDTH    = 3,
  parameter int SAT_MODE = MODE_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] limit,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_err,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             at_max,
  output logic             at_min,
  output logic             err
);
  logic [WIDTH-1:0] nxt;
  logic             evt;
  logic             step_err;
  logic             new_err;

  updn_next_calc #(.WIDTH(WIDTH), .SAT_MODE(SAT_MODE)) u_calc (
    .count    (count),
    .step     (step),
    .limit    (limit),
    .up       (up),
    .nxt      (nxt),
    .evt      (evt),
    .step_err (step_err)
  );

  // an illegal step only matters when it would actually be applied
  assign new_err = en & ~load & step_err;
  assign at_max  = (count == limit);
  assign at_min  = (count == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      wrap  <= 1'b0;
      err   <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (load) begin
        count <= (load_val > limit) ? limit : load_val;
      end else if (en) begin
        count <= nxt;
        wrap  <= evt;
      end
      err <= new_err | (err & ~clr_err);
    end
  end
endmodule

// File: tb/tb_param_updn_counter.sv
// Directed bench for param_updn_counter: a wrap-mode and a saturate-mode
// instance share stimulus; expected count/wrap go through a scoreboard queue.
module tb_param_updn_counter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0, up = 1'b1, load = 1'b0, clr_err = 1'b0;
  logic [2:0] step = 3'd0, limit = 3'd7, load_val = 3'd0;
  logic [2:0] cnt_w, cnt_s;
  logic       wrap_w, wrap_s, max_w, max_s, min_w, min_s, err_w, err_s;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      tag;
    int         sel;   // 0 wrap dut, 1 sat dut, 2 both
    logic [2:0] cw;
    logic       ww;
    logic [2:0] cs;
    logic       ws;
  } exp_t;
  exp_t q[$];

  param_updn_counter #(.WIDTH(3), .SAT_MODE(0)) dw (
    .clk(clk), .rst(rst), .en(en), .up(up), .step(step), .limit(limit),
    .load(load), .load_val(load_val), .clr_err(clr_err),
    .count(cnt_w), .wrap(wrap_w), .at_max(max_w), .at_min(min_w), .err(err_w)
  );

  param_updn_counter #(.WIDTH(3), .SAT_MODE(1)) ds (
    .clk(clk), .rst(rst), .en(en), .up(up), .step(step), .limit(limit),
    .load(load), .load_val(load_val), .clr_err(clr_err),
    .count(cnt_s), .wrap(wrap_s), .at_max(max_s), .at_min(min_s), .err(err_s)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // push expectation, clock one edge, pop and compare 1ns after the edge
  task automatic cyc(input string tag, input int sel,
                     input logic [2:0] cw, input logic ww,
                     input logic [2:0] cs, input logic ws);
    exp_t e;
    q.push_back('{tag, sel, cw, ww, cs, ws});
    @(posedge clk);
    #1;
    e = q.pop_front();
    if (e.sel != 1) begin
      chk({e.tag, ".cnt_w"}, 32'(cnt_w), 32'(e.cw));
      chk({e.tag, ".wrap_w"}, 32'(wrap_w), 32'(e.ww));
    end
    if (e.sel != 0) begin
      chk({e.tag, ".cnt_s"}, 32'(cnt_s), 32'(e.cs));
      chk({e.tag, ".wrap_s"}, 32'(wrap_s), 32'(e.ws));
    end
  endtask

  initial begin
    logic [2:0] seq [9];
    seq = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};

    // reset state
    #3;
    chk("rst.cnt_w", 32'(cnt_w), 0);
    chk("rst.wrap_w", 32'(wrap_w), 0);
    chk("rst.err_w", 32'(err_w), 0);
    chk("rst.cnt_s", 32'(cnt_s), 0);
    chk("rst.err_s", 32'(err_s), 0);
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rel.wrap_w", 32'(wrap_w), 0);
    chk("rel.cnt_w", 32'(cnt_w), 0);

    // wrap mode, limit 7, step 1 up: 1..7,0,1 with one wrap at 7->0
    limit = 3'd7; step = 3'd1; up = 1'b1; en = 1'b1;
    for (int i = 0; i < 9; i++)
      cyc($sformatf("up1[%0d]", i), 0, seq[i], (i == 7), 3'd0, 1'b0);

    // wrap mode, limit 5, step 2 down from 1: 5 (wrap), then 3
    en = 1'b0; load = 1'b1; load_val = 3'd1; limit = 3'd5; step = 3'd2; up = 1'b0;
    cyc("dn.load", 2, 3'd1, 1'b0, 3'd1, 1'b0);
    load = 1'b0; en = 1'b1;
    cyc("dn.wrap", 0, 3'd5, 1'b1, 3'd0, 1'b0);
    cyc("dn.next", 0, 3'd3, 1'b0, 3'd0, 1'b0);

    // saturate mode, limit 6, step 3 up from 4: 6 with wrap, twice
    en = 1'b0; load = 1'b1; load_val = 3'd4; limit = 3'd6; step = 3'd3; up = 1'b1;
    cyc("sat.load", 1, 3'd0, 1'b0, 3'd4, 1'b0);
    load = 1'b0; en = 1'b1;
    cyc("sat.up1", 1, 3'd0, 1'b0, 3'd6, 1'b1);
    cyc("sat.up2", 1, 3'd0, 1'b0, 3'd6, 1'b1);
    chk("sat.at_max", 32'(max_s), 1);
    en = 1'b0; load = 1'b1; load_val = 3'd0; up = 1'b0;
    cyc("sat.load0", 1, 3'd0, 1'b0, 3'd0, 1'b0);
    load = 1'b0; en = 1'b1;
    cyc("sat.dn0", 1, 3'd0, 1'b0, 3'd0, 1'b1);
    chk("sat.at_min", 32'(min_s), 1);

    // load clamps to limit; load beats en
    en = 1'b0; load = 1'b1; load_val = 3'd7; limit = 3'd4; step = 3'd1; up = 1'b1;
    cyc("ld.clamp", 2, 3'd4, 1'b0, 3'd4, 1'b0);
    chk("ld.at_max", 32'(max_w), 1);
    en = 1'b1; load_val = 3'd2;
    cyc("ld.prio", 2, 3'd2, 1'b0, 3'd2, 1'b0);

    // illegal step holds count and sets err
    load = 1'b0; limit = 3'd5; step = 3'd6;
    cyc("err.hold", 2, 3'd2, 1'b0, 3'd2, 1'b0);
    chk("err.set", 32'(err_w), 1);
    en = 1'b0; clr_err = 1'b1;
    cyc("err.clr", 0, 3'd2, 1'b0, 3'd0, 1'b0);
    chk("err.cleared", 32'(err_w), 0);
    en = 1'b1;
    cyc("err.same", 0, 3'd2, 1'b0, 3'd0, 1'b0);
    chk("err.clr_and_new", 32'(err_w), 1);
    en = 1'b0;
    cyc("err.clr2", 0, 3'd2, 1'b0, 3'd0, 1'b0);
    chk("err.cleared2", 32'(err_w), 0);
    clr_err = 1'b0;

    // limit lowered under the count
    load = 1'b1; load_val = 3'd6; limit = 3'd7; step = 3'd1; up = 1'b1;
    cyc("lim.load", 2, 3'd6, 1'b0, 3'd6, 1'b0);
    load = 1'b0; en = 1'b1; limit = 3'd2;
    cyc("lim.drop", 2, 3'd0, 1'b1, 3'd2, 1'b1);
    en = 1'b0;
    cyc("lim.deassert", 2, 3'd0, 1'b0, 3'd2, 1'b0);

    // limit 0 pins the count at 0
    limit = 3'd0; step = 3'd0; en = 1'b1;
    cyc("lim0", 0, 3'd0, 1'b0, 3'd0, 1'b0);
    chk("lim0.at_max", 32'(max_w), 1);
    chk("lim0.at_min", 32'(min_w), 1);

    // asynchronous reset mid-count, then restart from 0
    en = 1'b0; load = 1'b1; load_val = 3'd4; limit = 3'd7; step = 3'd1; up = 1'b1;
    cyc("ar.load", 0, 3'd4, 1'b0, 3'd0, 1'b0);
    load = 1'b0; en = 1'b1;
    cyc("ar.five", 0, 3'd5, 1'b0, 3'd0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("ar.cnt_async", 32'(cnt_w), 0);
    chk("ar.wrap_async", 32'(wrap_w), 0);
    @(posedge clk); #2;
    rst = 1'b0;
    cyc("ar.restart", 2, 3'd1, 1'b0, 3'd1, 1'b0);
    cyc("ar.next", 0, 3'd2, 1'b0, 3'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
